// File: rtl/restador_pkg.sv
// rtl/restador_pkg.sv - shared types and helpers for the bit-serial subtractor
// Purpose: FSM state encoding and bit-counter width helper used by restador_serie.
// Ports: none (package).
package restador_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} estado_t;

  // Counter width for a WIDTH-bit serial operation. WIDTH=1 still needs a
  // 1-bit counter because a zero-width vector is not legal.
  function automatic int cnt_width(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/restador_completo.sv
// rtl/restador_completo.sv - combinational 1-bit full subtractor
// Purpose: one bit of x - y - bin.
// Ports:
//   x    input  1  minuend bit
//   y    input  1  subtrahend bit
//   bin  input  1  borrow in
//   d    output 1  difference bit
//   bout output 1  borrow out
module restador_completo (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/restador_serie.sv
// rtl/restador_serie.sv - bit-serial subtractor with valid/ready handshakes
// Purpose: computes a - b LSB-first, one bit per clock, and presents the
//          WIDTH-bit difference plus borrow ({borrow,diff} = a - b as a
//          (WIDTH+1)-bit two's-complement value).
// Ports:
//   clk        input  1      rising-edge clock
//   rst        input  1      synchronous active-high reset
//   in_valid   input  1      operands valid
//   in_ready   output 1      block can accept operands (IDLE only)
//   a          input  WIDTH  minuend, unsigned
//   b          input  WIDTH  subtrahend, unsigned
//   out_valid  output 1      diff/borrow valid (DONE only)
//   out_ready  input  1      consumer accepts result
//   diff       output WIDTH  (a - b) mod 2^WIDTH, held until next completion
//   borrow     output 1      1 when a < b
module restador_serie
  import restador_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = cnt_width(WIDTH);

  estado_t          state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             accept, step, last_bit;
  logic             d_bit, br_next;
  logic [WIDTH-1:0] full_res;

  restador_completo u_completo (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (br_next)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // Partial result holds the WIDTH-1 bits already produced; the bit being
  // computed on the final edge is prepended so diff loads the whole word at
  // that same edge.
  generate
    if (WIDTH == 1) begin : g_w1
      assign full_res = d_bit;
    end else begin : g_wn
      logic [WIDTH-2:0] res_part;
      logic [WIDTH-2:0] res_shift;

      if (WIDTH == 2) begin : g_w2
        assign res_shift = d_bit;
      end else begin : g_wgt2
        assign res_shift = {d_bit, res_part[WIDTH-2:1]};
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          res_part <= '0;
        end else if (step) begin
          res_part <= res_shift;
        end
      end

      assign full_res = {d_bit, res_part};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      br   <= 1'b0;
      cnt  <= '0;
    end else if (step) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      br   <= br_next;
      cnt  <= cnt + CW'(1);
      if (last_bit) begin
        diff   <= full_res;
        borrow <= br_next;
      end
    end
  end

endmodule
